// File: rtl/ac_alu_pkg.sv
// Accumulator-path ALU shared definitions: function-unit result indices,
// default widths and the output buffer entry layout.
package ac_alu_pkg;

   localparam int OP_AND     = 0;
   localparam int OP_NOT     = 1;
   localparam int OP_OR      = 2;
   localparam int OP_XOR     = 3;
   localparam int OP_SUM     = 4;
   localparam int OP_SHIFT   = 5;
   localparam int AC_NUM_OPS = 6;
   localparam int AC_WIDTH   = 8;

   typedef struct packed {
      logic [AC_WIDTH-1:0] res;
      logic                zero;
      logic                neg;
      logic                sel_err;
   } ac_res_entry_t;

   // Entry is the result plus three flag bits
   function automatic int entry_w(input int w);
      return w + 3;
   endfunction

endpackage

// File: rtl/ac_skid_buf.sv
// Two-entry ready/valid FIFO; the head register drives the outputs directly
// so they never glitch and hold their last value when the buffer is empty.
module ac_skid_buf #(
   parameter int ENTRY_W = 11
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [ENTRY_W-1:0] i_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [ENTRY_W-1:0] o_data
);

   logic [1:0]         r_count;
   logic [ENTRY_W-1:0] r_head;
   logic [ENTRY_W-1:0] r_tail;
   logic               w_push;
   logic               w_pop;

   assign o_ready = reset_n && (r_count != 2'd2);
   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_head;
   assign w_push  = i_valid && o_ready;
   assign w_pop   = o_valid && i_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count <= 2'd0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         if (w_push && !w_pop)
            r_count <= r_count + 2'd1;
         else if (!w_push && w_pop)
            r_count <= r_count - 2'd1;

         // Full buffer cannot push, so a pop just promotes the tail
         if (w_pop && r_count == 2'd2)
            r_head <= r_tail;
         else if (w_push && (r_count == 2'd0 ||
                             (r_count == 2'd1 && w_pop)))
            r_head <= i_data;

         if (w_push && r_count == 2'd1 && !w_pop)
            r_tail <= i_data;
      end
   end

endmodule

// File: rtl/ac_output_mux_pipe.sv
// Registered one-hot output mux for the accumulator path with zero/negative
// flags, select-error tracking and a 2-entry ready/valid buffer.
module ac_output_mux_pipe
   import ac_alu_pkg::*;
#(
   parameter int WIDTH   = AC_WIDTH,
   parameter int NUM_SRC = AC_NUM_OPS
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_SRC*WIDTH-1:0] src_res,
   input  logic [NUM_SRC-1:0]       src_sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_res,
   output logic                     out_zero,
   output logic                     out_neg,
   output logic                     out_sel_err,
   output logic                     err_sticky,
   input  logic                     clr_err
);

   localparam int EW = entry_w(WIDTH);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             zero;
      logic             neg;
      logic             sel_err;
   } entry_t;

   logic             w_onehot;
   logic             w_push;
   logic [WIDTH-1:0] w_res;
   entry_t           w_in;
   entry_t           w_out;
   logic             r_err;

   assign w_onehot = (src_sel != '0) &&
                     ((src_sel & (src_sel - NUM_SRC'(1))) == '0);

   // A bad select yields zero rather than an OR-merge of sources
   always_comb begin
      w_res = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (src_sel[i])
            w_res = w_res | src_res[i*WIDTH +: WIDTH];
      if (!w_onehot)
         w_res = '0;
   end

   always_comb begin
      w_in         = '0;
      w_in.res     = w_res;
      w_in.zero    = (w_res == '0);
      w_in.neg     = w_res[WIDTH-1];
      w_in.sel_err = !w_onehot;
   end

   assign w_push = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!reset_n)
         r_err <= 1'b0;
      else if (w_push && !w_onehot)
         r_err <= 1'b1;
      else if (clr_err)
         r_err <= 1'b0;
   end

   ac_skid_buf #(
      .ENTRY_W(EW)
   ) u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .i_valid (in_valid),
      .o_ready (in_ready),
      .i_data  (w_in),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (w_out)
   );

   assign out_res     = w_out.res;
   assign out_zero    = w_out.zero;
   assign out_neg     = w_out.neg;
   assign out_sel_err = w_out.sel_err;
   assign err_sticky  = r_err;

endmodule
